// File: rtl/router_fsm.sv
// router_fsm: packet-reception controller that sequences the 1x3 router register/synchroniser datapath.
module router_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  fifo_empty0,
    input  logic                  fifo_empty1,
    input  logic                  fifo_empty2,
    input  logic                  soft_reset0,
    input  logic                  soft_reset1,
    input  logic                  soft_reset2,
    input  logic                  parity_done,
    input  logic                  low_pkt_valid,
    output logic                  detect_add,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  laf_state,
    output logic                  full_state,
    output logic                  write_enb_reg,
    output logic                  rst_int_reg,
    output logic                  busy
);
    typedef enum logic [2:0] {DA, WTE, LFD, LD, FFS, LAF, LP, CPE} state_t;
    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       sel_empty, sel_soft, hdr_empty;
    logic [7:0] out_d;
    logic       unused_hi;
    assign unused_hi = ^data_in[DATA_WIDTH-1:2];
    always_comb begin
        sel_empty = addr_q == 2'd0 ? fifo_empty0 : addr_q == 2'd1 ? fifo_empty1 : addr_q == 2'd2 ? fifo_empty2 : 1'b0;
        sel_soft  = addr_q == 2'd0 ? soft_reset0 : addr_q == 2'd1 ? soft_reset1 : addr_q == 2'd2 ? soft_reset2 : 1'b0;
        hdr_empty = data_in[1:0] == 2'd0 ? fifo_empty0 : data_in[1:0] == 2'd1 ? fifo_empty1 : fifo_empty2;
        addr_d    = (state_q == DA && pkt_valid) ? data_in[1:0] : addr_q;
        state_d   = DA;
        if (state_q != DA && sel_soft)
            state_d = DA;
        else
            case (state_q)
                DA:      state_d = (pkt_valid && data_in[1:0] != 2'd3) ? (hdr_empty ? LFD : WTE) : DA;
                WTE:     state_d = sel_empty ? LFD : WTE;
                LFD:     state_d = LD;
                LD:      state_d = fifo_full ? FFS : (!pkt_valid ? LP : LD);
                FFS:     state_d = fifo_full ? FFS : LAF;
                LAF:     state_d = parity_done ? DA : (low_pkt_valid ? LP : LD);
                LP:      state_d = CPE;
                CPE:     state_d = fifo_full ? FFS : DA;
                default: state_d = DA;
            endcase
        // Outputs are registered from the next state, so they track state_q exactly.
        out_d = {state_d == DA, state_d == LFD, state_d == LD, state_d == LAF, state_d == FFS,
                 state_d == LD || state_d == LP || state_d == LAF, state_d == CPE,
                 state_d != DA && state_d != LD};
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DA;
            addr_q  <= 2'd0;
            {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy} <= 8'b1000_0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy} <= out_d;
        end
    end
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: scoreboard bench for router_fsm driven by directed and random stimulus against a phase-level model.
module tb_router_fsm;
    logic       clk = 0, resetn = 0, pkt_valid = 0, fifo_full = 0;
    logic [7:0] data_in = 0;
    logic       fifo_empty0 = 1, fifo_empty1 = 1, fifo_empty2 = 1;
    logic       soft_reset0 = 0, soft_reset1 = 0, soft_reset2 = 0;
    logic       parity_done = 0, low_pkt_valid = 0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy;

    router_fsm #(.DATA_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
        .fifo_empty0(fifo_empty0), .fifo_empty1(fifo_empty1), .fifo_empty2(fifo_empty2),
        .soft_reset0(soft_reset0), .soft_reset1(soft_reset1), .soft_reset2(soft_reset2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum {P_IDLE, P_WAIT, P_HDR, P_BODY, P_STALL, P_RESUME, P_PAR, P_CHK} phase_t;
    phase_t     ph = P_IDLE;
    int         dest = 0;
    logic [7:0] expq[$];
    int         n_chk = 0, n_fail = 0, cyc = 0;

    bit       rn, pv, ff, pd, lpv;
    bit [7:0] d;
    bit [2:0] e, s;

    function automatic logic [7:0] expect_out(phase_t p);
        return {p == P_IDLE, p == P_HDR, p == P_BODY, p == P_RESUME, p == P_STALL,
                p == P_BODY || p == P_PAR || p == P_RESUME, p == P_CHK, !(p == P_IDLE || p == P_BODY)};
    endfunction

    task automatic tick();
        phase_t nph;
        bit     se, ss;
        @(negedge clk);
        resetn = rn; pkt_valid = pv; data_in = d; fifo_full = ff; parity_done = pd; low_pkt_valid = lpv;
        {fifo_empty2, fifo_empty1, fifo_empty0} = e;
        {soft_reset2, soft_reset1, soft_reset0} = s;
        if (!rn) begin
            ph = P_IDLE; dest = 0;
        end else begin
            se = dest < 3 ? e[dest] : 1'b0;
            ss = dest < 3 ? s[dest] : 1'b0;
            nph = ph;
            if (ph != P_IDLE && ss) nph = P_IDLE;
            else case (ph)
                P_IDLE:   if (pv && d[1:0] != 3) nph = e[d[1:0]] ? P_HDR : P_WAIT;
                P_WAIT:   if (se) nph = P_HDR;
                P_HDR:    nph = P_BODY;
                P_BODY:   nph = ff ? P_STALL : (pv ? P_BODY : P_PAR);
                P_STALL:  if (!ff) nph = P_RESUME;
                P_RESUME: nph = pd ? P_IDLE : (lpv ? P_PAR : P_BODY);
                P_PAR:    nph = P_CHK;
                P_CHK:    nph = ff ? P_STALL : P_IDLE;
                default:  nph = P_IDLE;
            endcase
            if (ph == P_IDLE && pv) dest = d[1:0];
            ph = nph;
        end
        expq.push_back(expect_out(ph));
    endtask

    task automatic idle(int n);
        rn = 1; pv = 0; ff = 0; pd = 0; lpv = 0; e = 3'b111; s = 0;
        repeat (n) tick();
    endtask

    initial begin
        logic [7:0] got, exp;
        forever begin
            @(posedge clk); #1;
            if (expq.size() != 0) begin
                exp = expq.pop_front();
                got = {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy};
                n_chk++;
                cyc++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d {da,lfd,ld,laf,full,we,rst,busy} got=%b expected=%b", cyc, got, exp);
                end
            end
        end
    end

    initial begin
        rn = 0; pv = 1; d = 8'h01; ff = 0; pd = 0; lpv = 0; e = 3'b111; s = 0;
        repeat (2) tick();
        rn = 1; tick();
        idle(6);
        pv = 1; d = 8'h0E; tick();
        repeat (3) begin d = 8'($urandom); tick(); end
        pv = 0; repeat (3) tick();
        idle(2);
        pv = 1; d = 8'h00; e = 3'b110; tick();
        pv = 0; repeat (5) tick();
        e = 3'b111; tick();
        idle(6);
        pv = 1; d = 8'h01; tick(); tick();
        ff = 1; repeat (4) tick();
        ff = 0; tick();
        lpv = 1; tick();
        lpv = 0; repeat (2) tick();
        idle(1);
        pv = 1; d = 8'h01; tick(); tick();
        ff = 1; repeat (2) tick();
        ff = 0; tick();
        pd = 1; tick();
        idle(2);
        pv = 1; d = 8'h01; tick(); tick();
        s = 3'b101; tick();
        s = 3'b010; tick();
        s = 0; idle(2);
        pv = 1; d = 8'h03; repeat (3) tick();
        idle(2);
        repeat (3000) begin
            rn  = $urandom_range(0, 99) != 0;
            pv  = $urandom_range(0, 3) != 0;
            d   = 8'($urandom);
            ff  = $urandom_range(0, 4) == 0;
            e   = {$urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7};
            s   = {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0};
            pd  = $urandom_range(0, 3) == 0;
            lpv = $urandom_range(0, 2) == 0;
            tick();
        end
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Packet-reception controller for the 1x3 router. It watches the incoming byte stream and the three output FIFOs, then sequences the register/synchroniser datapath. It drives address detection, first-byte/data/parity load strobes, FIFO write enable, full-stall handling and the internal parity-check reset. It sits between the input port and the router register/synchroniser blocks, and it is the only source of detect_add and write_enb_reg.

Parameters:
DATA_WIDTH, 8, width of data_in; the destination address is always data_in[1:0] of the header byte

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  synchronous, active-low reset
pkt_valid  input  1  high while header/payload bytes are presented; falls with the parity byte
data_in  input  DATA_WIDTH  input byte; bits [1:0] give the destination on the header cycle
fifo_full  input  1  selected-FIFO full flag from the synchroniser
fifo_empty0  input  1  FIFO0 empty
fifo_empty1  input  1  FIFO1 empty
fifo_empty2  input  1  FIFO2 empty
soft_reset0  input  1  FIFO0 timeout soft reset
soft_reset1  input  1  FIFO1 timeout soft reset
soft_reset2  input  1  FIFO2 timeout soft reset
parity_done  input  1  register block has captured the parity byte
low_pkt_valid  input  1  register block saw pkt_valid fall while stalled
detect_add  output  1  state == DECODE_ADDRESS
lfd_state  output  1  state == LOAD_FIRST_DATA
ld_state  output  1  state == LOAD_DATA
laf_state  output  1  state == LOAD_AFTER_FULL
full_state  output  1  state == FIFO_FULL_STATE
write_enb_reg  output  1  FIFO write request to the synchroniser
rst_int_reg  output  1  clears internal parity registers; state == CHECK_PARITY_ERROR
busy  output  1  input port must hold data_in

Behaviour:
- Reset: resetn sampled low at clk edge -> state = DECODE_ADDRESS and addr_q = 0.
  - Outputs after reset: detect_add=1; all other outputs 0, including busy=0.
- States are one-hot or binary (implementer's choice). All outputs are Moore, decoded from the registered state only; no input-to-output combinational path.
- Output decode:
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- addr_q (2b) loads data_in[1:0] when state==DECODE_ADDRESS and pkt_valid==1. It holds otherwise. sel_empty/sel_soft are fifo_emptyN/soft_resetN indexed by addr_q.
- Transition priority: resetn, then sel_soft (any state except DECODE_ADDRESS -> DECODE_ADDRESS next cycle), then the table below.
- DECODE_ADDRESS:
  - pkt_valid and data_in[1:0]=N (N in 0..2): fifo_emptyN=1 -> LOAD_FIRST_DATA; else -> WAIT_TILL_EMPTY.
  - data_in[1:0]=3 or !pkt_valid -> stay; the invalid-address packet is dropped and no write is issued.
- WAIT_TILL_EMPTY: sel_empty -> LOAD_FIRST_DATA; else stay.
- LOAD_FIRST_DATA: unconditional -> LOAD_DATA. The header byte is written here via the register block's lfd path.
- LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  - fifo_full wins over pkt_valid falling in the same cycle.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay. write_enb_reg=0 and busy=1 for the whole stall.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY: unconditional -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS. rst_int_reg=1 for exactly this cycle.
- Minimum packet latency, header accepted to back in DECODE_ADDRESS with no stall: header cycle, then LFD, then LD x payload, then LP, then CPE.
- Soft reset mid-packet: return to DECODE_ADDRESS one cycle later. The remainder of the packet is ignored until the next header with pkt_valid.
- Soft reset of a non-selected FIFO has no effect.
- Undefined state encodings recover to DECODE_ADDRESS.

Test Plan:
- Reset with pkt_valid=1, data_in=8'h01 held -> after resetn high, detect_add=1, busy=0. Next edge moves to LOAD_FIRST_DATA (fifo_empty1=1), lfd_state=1, busy=1.
- Header 8'h0E (addr 2), 3 payload bytes, pkt_valid falls on parity, all FIFOs empty/not full -> state sequence DA, LFD, LD, LD, LD, LP, CPE, DA. write_enb_reg high for 4 cycles, rst_int_reg one pulse.
- Header addr 0 with fifo_empty0=0 for 5 cycles -> WAIT_TILL_EMPTY, busy=1, write_enb_reg=0. fifo_empty0=1 -> LFD next cycle.
- fifo_full=1 during LD for 4 cycles -> full_state=1 and write_enb_reg=0 for 4 cycles. Then LAF; with low_pkt_valid=1 -> LP; with parity_done=1 -> DA.
- Header addr 1; soft_reset1 pulses in LD -> DA next cycle, detect_add=1. soft_reset0/2 pulses during the same kind of packet -> no state change.
- Header data_in=8'h03 with pkt_valid=1 -> stays DA, write_enb_reg never asserted, busy=0.
